iopmp_cfg_tlul_host: RTL and testbench
======================================

Name: iopmp_cfg_tlul_host

Overview:
TL-UL initiator that programs and reads back the IOPMP configuration register file (version, HWCFG, MDCFG, SRCMD, ENTRY, ERR registers) over the same TL-UL port the IOPMP register block responds on. It accepts single-word commands from a local controller (boot sequencer or test harness), issues one TL-UL A-channel request, collects the D-channel response, and returns read data and error status. It allows at most one outstanding transaction.

Parameters:
AddrWidth, 14, TL-UL address width, matching the register-file offset space.
DataWidth, 32, TL-UL data width. Mask width is DataWidth/8.
SourceWidth, 8, width of the a_source/d_source ID.
SinkWidth, 8, width of d_sink, which is received and ignored.
TimeoutCycles, 255, maximum cycles to wait for d_valid before aborting with an error.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  command accepted when high together with cmd_valid_i
cmd_write_i  in  1  1 = write, 0 = read
cmd_addr_i  in  AddrWidth  register byte offset
cmd_wdata_i  in  DataWidth  write data
cmd_wmask_i  in  DataWidth/8  write byte enables
rsp_valid_o  out  1  response available
rsp_ready_i  in  1  response consumed
rsp_rdata_o  out  DataWidth  read data (0 for writes and errors)
rsp_err_o  out  1  d_error, misalignment, source mismatch or timeout
a_valid_o  out  1  TL-UL A valid
a_ready_i  in  1  TL-UL A ready
a_opcode_o  out  3  0 = PutFullData, 1 = PutPartialData, 4 = Get
a_size_o  out  2  always 2 (4 bytes)
a_address_o  out  AddrWidth  request address
a_source_o  out  SourceWidth  transaction ID
a_mask_o  out  DataWidth/8  byte mask
a_data_o  out  DataWidth  write data
d_valid_i  in  1  TL-UL D valid
d_ready_o  out  1  TL-UL D ready
d_opcode_i  in  3  0 = AccessAck, 1 = AccessAckData
d_source_i  in  SourceWidth  response ID
d_sink_i  in  SinkWidth  ignored
d_data_i  in  DataWidth  read data
d_error_i  in  1  responder error

Behaviour:
- Reset (rst_ni = 0, asynchronous) forces:
  - all outputs to 0;
  - FSM to IDLE;
  - source counter to 0;
  - timeout counter to 0.
  - A reset mid-transaction abandons that transaction and issues no response.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE:
  - cmd_ready_o = 1.
  - On cmd_valid_i, capture the command.
  - Misaligned address (cmd_addr_i[1:0] != 0): go directly to DONE with rsp_err_o = 1. No bus transaction is issued.
  - Otherwise go to REQ.
- REQ:
  - a_valid_o = 1, with all A fields held stable until a_ready_i.
  - a_address_o = cmd_addr_i & 14'h3FFC.
  - Read: opcode 4, mask all ones, data 0.
  - Write: opcode 0 if the mask is all ones, otherwise opcode 1. Mask = cmd_wmask_i.
  - On a_valid_o && a_ready_i: go to RESP and clear the timeout counter.
- RESP:
  - d_ready_o = 1.
  - On d_valid_i, latch the response and go to DONE:
    - rsp_err_o = d_error_i | (d_source_i != issued ID) | (read && d_opcode_i != 1) | (write && d_opcode_i != 0).
    - rsp_rdata_o = d_data_i only for an error-free read, otherwise 0.
  - If no d_valid_i arrives, the counter increments each cycle. When it reaches TimeoutCycles: go to DONE with rsp_err_o = 1 and rsp_rdata_o = 0.
  - A D beat arriving after a timeout is accepted while idle and discarded. d_ready_o = 1 in IDLE as well.
- DONE:
  - rsp_valid_o = 1, with rsp_rdata_o and rsp_err_o held stable.
  - On rsp_ready_i: go to IDLE and increment the source counter, wrapping 0xFF to 0x00.
  - The source counter increments only for transactions actually issued on the bus.
- Latency:
  - Command accepted at cycle 0; a_valid_o at cycle 1.
  - With a_ready_i = 1 and d_valid_i returned one cycle after the A handshake, rsp_valid_o is asserted at cycle 3.
- cmd_ready_o = 0 outside IDLE.
- d_ready_o = 0 in REQ and DONE.

Test Plan:
1. Read 14'h0000, responder returns AccessAckData with data 32'h0000_0100 -> A: opcode 4, mask F, source 0; rsp_rdata_o = 32'h100, rsp_err_o = 0.
2. Write 14'h2008, data 32'h0000_0007, mask F; then write mask 4'h1 -> A opcodes 0 then 1, sources 0 then 1; both AccessAck; rsp_err_o = 0.
3. Command address 14'h1002 -> no a_valid_o pulse; rsp_valid_o within 1 cycle with rsp_err_o = 1; next issued source is still 0.
4. a_ready_i held low for 5 cycles -> a_valid_o stays high with A fields unchanged; handshake completes on cycle 6.
5. No D response, TimeoutCycles = 16 -> rsp_err_o = 1 after 16 cycles in RESP; a late D beat is absorbed; next read completes correctly.
6. d_error_i = 1, or d_source_i mismatched -> rsp_err_o = 1, rsp_rdata_o = 0. Assert rst_ni low while in REQ -> a_valid_o drops immediately and source counter returns to 0.

Source files
------------

// File: rtl/iopmp_cfg_tlul_host.sv
// ============================================================================
// Module   : iopmp_cfg_tlul_host
// Brief    : Single-outstanding TL-UL initiator that issues one register access
//            per local command and returns the read data and error status.
// Revision : 1.0
// ============================================================================
`default_nettype none

module iopmp_cfg_tlul_host #(
   parameter int ADDR_WIDTH     = 14,
   parameter int DATA_WIDTH     = 32,
   parameter int SOURCE_WIDTH   = 8,
   parameter int SINK_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      cmd_valid_i,
   output logic                      cmd_ready_o,
   input  logic                      cmd_write_i,
   input  logic [ADDR_WIDTH-1:0]     cmd_addr_i,
   input  logic [DATA_WIDTH-1:0]     cmd_wdata_i,
   input  logic [DATA_WIDTH/8-1:0]   cmd_wmask_i,
   output logic                      rsp_valid_o,
   input  logic                      rsp_ready_i,
   output logic [DATA_WIDTH-1:0]     rsp_rdata_o,
   output logic                      rsp_err_o,
   output logic                      a_valid_o,
   input  logic                      a_ready_i,
   output logic [2:0]                a_opcode_o,
   output logic [1:0]                a_size_o,
   output logic [ADDR_WIDTH-1:0]     a_address_o,
   output logic [SOURCE_WIDTH-1:0]   a_source_o,
   output logic [DATA_WIDTH/8-1:0]   a_mask_o,
   output logic [DATA_WIDTH-1:0]     a_data_o,
   input  logic                      d_valid_i,
   output logic                      d_ready_o,
   input  logic [2:0]                d_opcode_i,
   input  logic [SOURCE_WIDTH-1:0]   d_source_i,
   input  logic [SINK_WIDTH-1:0]     d_sink_i,
   input  logic [DATA_WIDTH-1:0]     d_data_i,
   input  logic                      d_error_i
);

   localparam int MW  = DATA_WIDTH / 8;
   localparam int TCW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [2:0] c_OP_PUT_FULL = 3'd0;
   localparam logic [2:0] c_OP_PUT_PART = 3'd1;
   localparam logic [2:0] c_OP_GET      = 3'd4;
   localparam logic [2:0] c_OP_ACK      = 3'd0;
   localparam logic [2:0] c_OP_ACK_DATA = 3'd1;

   localparam logic [TCW-1:0]        c_TC_LAST    = TCW'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] c_WORD_ALIGN = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

   logic [1:0]              r_state, w_next;
   logic                    r_write, r_issued, r_err;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic [DATA_WIDTH-1:0]   r_wdata, r_rdata;
   logic [MW-1:0]           r_wmask;
   logic [SOURCE_WIDTH-1:0] r_src;
   logic [TCW-1:0]          r_tcnt;

   logic w_cmd_fire, w_misaligned, w_a_fire, w_d_fire, w_timeout, w_rsp_fire, w_d_err;
   logic w_unused_sink;

   assign w_unused_sink = ^d_sink_i;

   assign w_misaligned = |cmd_addr_i[1:0];
   assign w_cmd_fire   = (r_state == S_IDLE) && cmd_valid_i;
   assign w_a_fire     = (r_state == S_REQ)  && a_ready_i;
   assign w_d_fire     = (r_state == S_RESP) && d_valid_i;
   assign w_timeout    = (r_state == S_RESP) && !d_valid_i && (r_tcnt == c_TC_LAST);
   assign w_rsp_fire   = (r_state == S_DONE) && rsp_ready_i;

   assign w_d_err = d_error_i | (d_source_i != r_src) |
                    (r_write ? (d_opcode_i != c_OP_ACK) : (d_opcode_i != c_OP_ACK_DATA));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_cmd_fire) w_next = w_misaligned ? S_DONE : S_REQ;
         S_REQ:   if (w_a_fire) w_next = S_RESP;
         S_RESP:  if (w_d_fire || w_timeout) w_next = S_DONE;
         S_DONE:  if (w_rsp_fire) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Late D beats after a timeout are drained in IDLE, hence d_ready there too.
   always_comb begin
      cmd_ready_o = 1'b0;
      d_ready_o   = 1'b0;
      a_valid_o   = 1'b0;
      a_opcode_o  = 3'd0;
      a_size_o    = 2'd0;
      a_address_o = '0;
      a_source_o  = '0;
      a_mask_o    = '0;
      a_data_o    = '0;
      rsp_valid_o = 1'b0;
      rsp_rdata_o = '0;
      rsp_err_o   = 1'b0;
      case (r_state)
         S_IDLE: begin
            cmd_ready_o = rst_ni;
            d_ready_o   = rst_ni;
         end
         S_REQ: begin
            a_valid_o   = 1'b1;
            a_size_o    = 2'd2;
            a_address_o = r_addr & c_WORD_ALIGN;
            a_source_o  = r_src;
            if (r_write) begin
               a_opcode_o = (&r_wmask) ? c_OP_PUT_FULL : c_OP_PUT_PART;
               a_mask_o   = r_wmask;
               a_data_o   = r_wdata;
            end else begin
               a_opcode_o = c_OP_GET;
               a_mask_o   = '1;
            end
         end
         S_RESP: d_ready_o = 1'b1;
         S_DONE: begin
            rsp_valid_o = 1'b1;
            rsp_rdata_o = r_rdata;
            rsp_err_o   = r_err;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_write  <= 1'b0;
         r_issued <= 1'b0;
         r_err    <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_wmask  <= '0;
         r_rdata  <= '0;
         r_src    <= '0;
         r_tcnt   <= '0;
      end else begin
         if (w_cmd_fire) begin
            r_write  <= cmd_write_i;
            r_addr   <= cmd_addr_i;
            r_wdata  <= cmd_wdata_i;
            r_wmask  <= cmd_wmask_i;
            r_issued <= !w_misaligned;
            r_err    <= w_misaligned;
            r_rdata  <= '0;
         end
         if (w_a_fire) begin
            r_tcnt <= '0;
         end else if ((r_state == S_RESP) && !d_valid_i && !w_timeout) begin
            r_tcnt <= r_tcnt + 1'b1;
         end
         if (w_d_fire) begin
            r_err   <= w_d_err;
            r_rdata <= (!r_write && !w_d_err) ? d_data_i : '0;
         end else if (w_timeout) begin
            r_err   <= 1'b1;
            r_rdata <= '0;
         end
         // Only bus-issued transactions consume a source ID.
         if (w_rsp_fire && r_issued) r_src <= r_src + 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_iopmp_cfg_tlul_host.sv
// ============================================================================
// Module   : tb_iopmp_cfg_tlul_host
// Brief    : Directed vector bench for iopmp_cfg_tlul_host (timeout set to 16).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_iopmp_cfg_tlul_host;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        cmd_valid_i = 1'b0, cmd_ready_o, cmd_write_i = 1'b0;
   logic [13:0] cmd_addr_i = '0;
   logic [31:0] cmd_wdata_i = '0;
   logic [3:0]  cmd_wmask_i = '0;
   logic        rsp_valid_o, rsp_ready_i = 1'b0, rsp_err_o;
   logic [31:0] rsp_rdata_o;
   logic        a_valid_o, a_ready_i = 1'b0;
   logic [2:0]  a_opcode_o;
   logic [1:0]  a_size_o;
   logic [13:0] a_address_o;
   logic [7:0]  a_source_o;
   logic [3:0]  a_mask_o;
   logic [31:0] a_data_o;
   logic        d_valid_i = 1'b0, d_ready_o, d_error_i = 1'b0;
   logic [2:0]  d_opcode_i = '0;
   logic [7:0]  d_source_i = '0, d_sink_i = 8'h5A;
   logic [31:0] d_data_i = '0;

   int n_vec  = 0;
   int n_fail = 0;

   always #5 clk_i = ~clk_i;

   iopmp_cfg_tlul_host #(
      .ADDR_WIDTH(14), .DATA_WIDTH(32), .SOURCE_WIDTH(8), .SINK_WIDTH(8), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
      .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i), .cmd_wmask_i(cmd_wmask_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
      .rsp_err_o(rsp_err_o),
      .a_valid_o(a_valid_o), .a_ready_i(a_ready_i), .a_opcode_o(a_opcode_o),
      .a_size_o(a_size_o), .a_address_o(a_address_o), .a_source_o(a_source_o),
      .a_mask_o(a_mask_o), .a_data_o(a_data_o),
      .d_valid_i(d_valid_i), .d_ready_o(d_ready_o), .d_opcode_i(d_opcode_i),
      .d_source_i(d_source_i), .d_sink_i(d_sink_i), .d_data_i(d_data_i),
      .d_error_i(d_error_i)
   );

   typedef struct {
      logic        wr;
      logic        bad;      // misaligned: no bus transaction expected
      logic [13:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [2:0]  d_op;
      logic [7:0]  d_src;
      logic [31:0] d_data;
      logic        d_err;
      logic [2:0]  e_op;
      logic [13:0] e_addr;
      logic [3:0]  e_mask;
      logic [31:0] e_data;
      logic [7:0]  e_src;
      logic [31:0] e_rdata;
      logic        e_err;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_a(input vec_t v);
      chk("a_valid",   32'(a_valid_o),   32'd1);
      chk("a_opcode",  32'(a_opcode_o),  32'(v.e_op));
      chk("a_size",    32'(a_size_o),    32'd2);
      chk("a_address", 32'(a_address_o), 32'(v.e_addr));
      chk("a_source",  32'(a_source_o),  32'(v.e_src));
      chk("a_mask",    32'(a_mask_o),    32'(v.e_mask));
      chk("a_data",    a_data_o,         v.e_data);
   endtask

   task automatic issue_cmd(input vec_t v);
      @(negedge clk_i);
      chk("cmd_ready_idle", 32'(cmd_ready_o), 32'd1);
      cmd_valid_i = 1'b1;
      cmd_write_i = v.wr;
      cmd_addr_i  = v.addr;
      cmd_wdata_i = v.wdata;
      cmd_wmask_i = v.wmask;
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
   endtask

   task automatic d_beat(input vec_t v);
      chk("d_ready_resp", 32'(d_ready_o), 32'd1);
      chk("rsp_valid_resp", 32'(rsp_valid_o), 32'd0);
      d_valid_i  = 1'b1;
      d_opcode_i = v.d_op;
      d_source_i = v.d_src;
      d_data_i   = v.d_data;
      d_error_i  = v.d_err;
      @(negedge clk_i);
      d_valid_i  = 1'b0;
      d_error_i  = 1'b0;
   endtask

   task automatic finish_rsp(input vec_t v);
      chk("rsp_valid", 32'(rsp_valid_o), 32'd1);
      chk("rsp_rdata", rsp_rdata_o, v.e_rdata);
      chk("rsp_err",   32'(rsp_err_o), 32'(v.e_err));
      chk("d_ready_done", 32'(d_ready_o), 32'd0);
      @(negedge clk_i);
      chk("rsp_hold_rdata", rsp_rdata_o, v.e_rdata);
      chk("rsp_hold_err",   32'(rsp_err_o), 32'(v.e_err));
      rsp_ready_i = 1'b1;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      chk("rsp_valid_after", 32'(rsp_valid_o), 32'd0);
   endtask

   task automatic run_vec(input vec_t v);
      issue_cmd(v);
      if (v.bad) begin
         chk("a_valid_misaligned", 32'(a_valid_o), 32'd0);
      end else begin
         chk_a(v);
         chk("cmd_ready_req", 32'(cmd_ready_o), 32'd0);
         chk("d_ready_req", 32'(d_ready_o), 32'd0);
         a_ready_i = 1'b1;
         @(negedge clk_i);
         a_ready_i = 1'b0;
         d_beat(v);
      end
      finish_rsp(v);
   endtask

   vec_t vt[10];
   vec_t sv;

   initial begin
      //         wr   bad  addr      wdata         wmask dop   dsrc   ddata         derr eop   eaddr     emask edata         esrc   erdata        eerr
      vt[0] = '{1'b0,1'b1,14'h1002,32'h0,        4'h0,3'd1,8'd0,  32'h0,        1'b0,3'd4,14'h1000,4'hF,32'h0,        8'd0,  32'h0,        1'b1};
      vt[1] = '{1'b0,1'b0,14'h0000,32'h0,        4'h0,3'd1,8'd0,  32'h0000_0100,1'b0,3'd4,14'h0000,4'hF,32'h0,        8'd0,  32'h0000_0100,1'b0};
      vt[2] = '{1'b1,1'b0,14'h2008,32'h7,        4'hF,3'd0,8'd1,  32'hDEAD_BEEF,1'b0,3'd0,14'h2008,4'hF,32'h7,        8'd1,  32'h0,        1'b0};
      vt[3] = '{1'b1,1'b0,14'h2008,32'h7,        4'h1,3'd0,8'd2,  32'h0,        1'b0,3'd1,14'h2008,4'h1,32'h7,        8'd2,  32'h0,        1'b0};
      vt[4] = '{1'b0,1'b0,14'h1000,32'h0,        4'h0,3'd1,8'd3,  32'h0000_0055,1'b1,3'd4,14'h1000,4'hF,32'h0,        8'd3,  32'h0,        1'b1};
      vt[5] = '{1'b0,1'b0,14'h0800,32'h0,        4'h0,3'd1,8'h99, 32'h1234_5678,1'b0,3'd4,14'h0800,4'hF,32'h0,        8'd4,  32'h0,        1'b1};
      vt[6] = '{1'b0,1'b0,14'h0804,32'h0,        4'h0,3'd0,8'd5,  32'h1111_2222,1'b0,3'd4,14'h0804,4'hF,32'h0,        8'd5,  32'h0,        1'b1};
      vt[7] = '{1'b1,1'b1,14'h3001,32'hAAAA_5555,4'h6,3'd0,8'd0,  32'h0,        1'b0,3'd1,14'h3000,4'h6,32'h0,        8'd6,  32'h0,        1'b1};
      vt[8] = '{1'b0,1'b0,14'h0010,32'h0,        4'h0,3'd1,8'd6,  32'hCAFE_F00D,1'b0,3'd4,14'h0010,4'hF,32'h0,        8'd6,  32'hCAFE_F00D,1'b0};
      vt[9] = '{1'b1,1'b0,14'h0014,32'h8000_0001,4'hF,3'd1,8'd7,  32'h0,        1'b0,3'd0,14'h0014,4'hF,32'h8000_0001,8'd7,  32'h0,        1'b1};

      // Outputs must all be low while reset is held.
      #12;
      chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd0);
      chk("rst_a_valid",   32'(a_valid_o),   32'd0);
      chk("rst_d_ready",   32'(d_ready_o),   32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata_o,      32'd0);
      chk("rst_a_source",  32'(a_source_o),  32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(vt[i]);

      // A-channel backpressure: fields held while a_ready is low for 5 cycles.
      sv = '{1'b0,1'b0,14'h0020,32'h0,4'h0,3'd1,8'd8,32'h0BAD_F00D,1'b0,3'd4,14'h0020,4'hF,32'h0,8'd8,32'h0BAD_F00D,1'b0};
      issue_cmd(sv);
      for (int c = 0; c < 5; c++) begin
         chk_a(sv);
         @(negedge clk_i);
      end
      chk_a(sv);
      a_ready_i = 1'b1;
      @(negedge clk_i);
      a_ready_i = 1'b0;
      d_beat(sv);
      finish_rsp(sv);

      // No D response: timeout after 16 cycles in RESP, then a late beat is drained.
      sv = '{1'b0,1'b0,14'h0024,32'h0,4'h0,3'd1,8'd9,32'h7777_7777,1'b0,3'd4,14'h0024,4'hF,32'h0,8'd9,32'h0,1'b1};
      issue_cmd(sv);
      chk_a(sv);
      a_ready_i = 1'b1;
      @(negedge clk_i);
      a_ready_i = 1'b0;
      begin
         int cnt;
         cnt = 0;
         while (!rsp_valid_o && cnt < 100) begin
            cnt++;
            @(negedge clk_i);
         end
         chk("timeout_cycles", 32'(cnt), 32'd16);
      end
      finish_rsp(sv);
      chk("d_ready_idle", 32'(d_ready_o), 32'd1);
      d_valid_i  = 1'b1;
      d_opcode_i = 3'd1;
      d_source_i = 8'd9;
      d_data_i   = 32'h7777_7777;
      @(negedge clk_i);
      d_valid_i = 1'b0;
      chk("late_beat_rsp_valid", 32'(rsp_valid_o), 32'd0);
      chk("late_beat_cmd_ready", 32'(cmd_ready_o), 32'd1);
      sv = '{1'b0,1'b0,14'h0028,32'h0,4'h0,3'd1,8'd10,32'h0000_00A5,1'b0,3'd4,14'h0028,4'hF,32'h0,8'd10,32'h0000_00A5,1'b0};
      run_vec(sv);

      // Reset while in REQ drops a_valid immediately and restarts source IDs at 0.
      sv = '{1'b1,1'b0,14'h0030,32'h0000_0042,4'hF,3'd0,8'd11,32'h0,1'b0,3'd0,14'h0030,4'hF,32'h0000_0042,8'd11,32'h0,1'b0};
      issue_cmd(sv);
      chk_a(sv);
      #2 rst_ni = 1'b0;
      #1;
      chk("rst_req_a_valid",   32'(a_valid_o),   32'd0);
      chk("rst_req_cmd_ready", 32'(cmd_ready_o), 32'd0);
      chk("rst_req_rsp_valid", 32'(rsp_valid_o), 32'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      sv = '{1'b0,1'b0,14'h0004,32'h0,4'h0,3'd1,8'd0,32'h0000_0003,1'b0,3'd4,14'h0004,4'hF,32'h0,8'd0,32'h0000_0003,1'b0};
      run_vec(sv);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
